// File: rtl/log_mac_pkg.sv
// ---------------------------------------------------------------------------
// log_mac_pkg
// Shared definitions for the log-domain dot-product accumulator:
//   - state_t : accumulator FSM states (IDLE, ACC, DRAIN, DONE)
//   - PROD_W  : default product width from the upstream log multiplier
//   - ACC_W   : default accumulator width (must be >= PROD_W)
//   - LEN_W   : default vector-length counter width
// ---------------------------------------------------------------------------
package log_mac_pkg;

   localparam int PROD_W = 64;
   localparam int ACC_W  = 64;
   localparam int LEN_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/log_mac_sat_add.sv
// ---------------------------------------------------------------------------
// log_mac_sat_add
// Combinational unsigned adder for the accumulator datapath.
//   acc_in  in  ACC_W   current accumulator value
//   prod_in in  PROD_W  product, zero-extended to ACC_W before the add
//   sum_out out ACC_W   next accumulator value (wrapped or clamped)
//   carry   out 1       carry out of ACC_W bits (overflow indication)
// Build option: LOG_MAC_SATURATE_EN clamps the sum to all ones on carry.
// Without it the sum wraps modulo 2^ACC_W. The carry output is the same in
// both builds.
// ---------------------------------------------------------------------------
module log_mac_sat_add #(
   parameter int PROD_W = 64,
   parameter int ACC_W  = 64
) (
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [PROD_W-1:0] prod_in,
   output logic [ACC_W-1:0]  sum_out,
   output logic              carry
);

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W:0]   sum_full;

   always_comb begin
      prod_ext = ACC_W'(prod_in);
      sum_full = {1'b0, acc_in} + {1'b0, prod_ext};
      carry    = sum_full[ACC_W];
`ifdef LOG_MAC_SATURATE_EN
      // Once clamped, any further non-zero add carries again and re-clamps,
      // and a zero add leaves all ones untouched, so the value holds.
      sum_out  = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
      sum_out  = sum_full[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/log_mac_acc.sv
// ---------------------------------------------------------------------------
// log_mac_acc
// Dot-product accumulator: sums a job of vec_len unsigned products coming
// from a log multiplier and hands the total out on a valid/ready port.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, vec_len      start a job of vec_len products (IDLE only)
//   busy                FSM not in IDLE
//   prod_valid/ready    product input handshake, prod = product value
//   acc_valid/ready     result handshake, acc_data = sum, acc_ovf = sticky
//                       carry-out seen during the job
// Accepted products go through a one-deep register and are added on the
// following cycle, so the result appears two cycles after the last accept.
// Build option: LOG_MAC_SATURATE_EN (clamp instead of wrap, see adder).
// ---------------------------------------------------------------------------
module log_mac_acc #(
   parameter int PROD_W = log_mac_pkg::PROD_W,
   parameter int ACC_W  = log_mac_pkg::ACC_W,
   parameter int LEN_W  = log_mac_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  vec_len,
   output logic              busy,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic [ACC_W-1:0]  acc_data,
   output logic              acc_ovf
);

   import log_mac_pkg::*;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] pipe_q, pipe_d;
   logic              pipe_vld_q, pipe_vld_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              ovf_q, ovf_d;

   logic [ACC_W-1:0]  add_sum;
   logic              add_carry;
   logic              prod_hs;

   log_mac_sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .acc_in  (acc_q),
      .prod_in (pipe_q),
      .sum_out (add_sum),
      .carry   (add_carry)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pipe_d     = pipe_q;
      pipe_vld_d = 1'b0;
      acc_d      = acc_q;
      ovf_d      = ovf_q;

      prod_ready = (state_q == ST_ACC) && (cnt_q != '0);
      prod_hs    = prod_valid & prod_ready;

      // The add for a product captured last cycle; this covers both the
      // steady ACC stream and the final add in DRAIN.
      if (pipe_vld_q) begin
         acc_d = add_sum;
         ovf_d = ovf_q | add_carry;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (vec_len != '0) begin
                  cnt_d   = vec_len;
                  state_d = ST_ACC;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_ACC: begin
            if (prod_hs) begin
               pipe_d     = prod;
               pipe_vld_d = 1'b1;
               cnt_d      = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (acc_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         pipe_q     <= '0;
         pipe_vld_q <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pipe_q     <= pipe_d;
         pipe_vld_q <= pipe_vld_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign acc_valid = (state_q == ST_DONE);
   assign acc_data  = acc_q;
   assign acc_ovf   = ovf_q;

endmodule

// File: doc/log_mac_acc.md
LOG_MAC_ACC -- requirements
Module: log_mac_acc

Interface
REQ-001 SHALL have parameter PROD_W, default 64, meaning product width from the upstream log multiplier.
REQ-002 SHALL have parameter ACC_W, default 64, meaning accumulator width; ACC_W >= PROD_W.
REQ-003 SHALL have parameter LEN_W, default 8, meaning vector-length counter width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
REQ-005 SHALL have the following data and handshake ports:
- start  in  1  begin a dot-product job
- vec_len  in  LEN_W  number of products in the job
- busy  out  1  state != IDLE
- prod_valid  in  1  product valid
- prod_ready  out  1  product accept
- prod  in  PROD_W  unsigned product from the multiplier
- acc_valid  out  1  result valid
- acc_ready  in  1  result consumed
- acc_data  out  ACC_W  accumulated sum
- acc_ovf  out  1  sticky overflow for the job

Function
REQ-006 SHALL implement FSM states IDLE, ACC, DRAIN, DONE.
REQ-007 IDLE behaviour:
- start=1 with vec_len!=0: load remaining count = vec_len, clear accumulator and acc_ovf, go to ACC.
- start=1 with vec_len==0: clear accumulator, go to DONE.
REQ-008 ACC behaviour:
- prod_ready=1 while remaining count != 0.
- Each handshake (prod_valid & prod_ready) captures prod into a one-deep pipeline register and decrements the count.
REQ-009 A captured product SHALL be added to the accumulator on the cycle after capture; back-to-back accepts sustain one add per cycle.
REQ-010 The handshake that brings the count to 0 SHALL move the FSM to DRAIN. DRAIN performs the final add and moves to DONE on the next cycle.
REQ-011 The result SHALL be visible as acc_valid=1 two cycles after the final accept.
REQ-012 DONE behaviour:
- acc_valid=1; acc_data and acc_ovf stable.
- acc_valid & acc_ready returns the FSM to IDLE.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 prod_ready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-015 Bubbles (prod_valid=0) SHALL not change the accumulator or the count.
REQ-016 Addition SHALL be unsigned, with prod zero-extended to ACC_W.
REQ-017 Overflow SHALL be detected as a carry out of ACC_W bits. On overflow acc_ovf sets and stays set until the next job start.
REQ-018 A zero product SHALL be accumulated like any other value; no special case.

Reset
REQ-019 rst_n=0 SHALL immediately force all outputs and state to reset values, including mid-job; no partial result is emitted:
- FSM = IDLE
- busy=0, prod_ready=0, acc_valid=0, acc_data=0, acc_ovf=0
- count and pipeline register cleared

Configuration
REQ-020 With macro LOG_MAC_SATURATE_EN defined, an overflowing add SHALL clamp the accumulator to all ones and hold it there for the rest of the job.
REQ-021 Without LOG_MAC_SATURATE_EN, the accumulator SHALL wrap modulo 2^ACC_W.
REQ-022 acc_ovf SHALL behave identically in both builds.

Structure
REQ-023 Package log_mac_pkg SHALL hold:
- the FSM state enum
- default width constants PROD_W, ACC_W, LEN_W
REQ-024 Sub-module log_mac_sat_add SHALL contain the combinational ACC_W adder, carry-out and the macro-controlled clamp. All sequential logic stays in log_mac_acc.

Verification (ACC_W=64)
REQ-025 vec_len=3, products 5, 7, 11 back-to-back -> acc_valid two cycles after third accept, acc_data=23, acc_ovf=0.
REQ-026 start with vec_len=0 -> DONE next cycle, acc_data=0, prod_ready never asserted.
REQ-027 vec_len=2, products 2^63 and 2^63 -> acc_ovf=1; acc_data=64'hFFFF_FFFF_FFFF_FFFF with LOG_MAC_SATURATE_EN, 0 without.
REQ-028 vec_len=2, products 4 and 6 with 3 idle cycles between, acc_ready held low 5 cycles, start pulsed in DONE -> acc_data=10 stable throughout, start ignored, IDLE after acc_ready.
REQ-029 vec_len=4, rst_n asserted after 2 accepts -> all outputs at reset values the same cycle; then vec_len=1, product 9 -> acc_data=9, acc_ovf=0.
